poly_ct_pack: RTL and testbench

POLY_CT_PACK -- requirements
Module: poly_ct_pack

---
 rtl/ntru_pkg.sv | 16 +
 rtl/bit_packer.sv | 61 ++++++
 rtl/poly_ct_pack.sv | 119 +++++++++++
 tb/tb_poly_ct_pack.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_pkg.sv
// Shared constants and state encoding for the NTRU ciphertext packer.
package ntru_pkg;

    localparam int NTRU_N     = 701;
    localparam int Q_BITS     = 13;
    localparam int RQ_BITS    = 9113;
    localparam int PACK_BYTES = 1138;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bit_packer.sv
// LSB-first bit accumulator: takes IN_W-bit words, emits bytes from the
// bottom. In flush mode a final partial byte is emitted zero-padded.
module bit_packer #(
    parameter int IN_W = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    output logic [7:0]      out_data,
    input  logic            out_ready,
    output logic            drained
);

    localparam int ACC_W = IN_W + 8;
    localparam int CNT_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] acc_q, acc_d, acc_s;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_s;
    logic             out_fire;

    assign in_ready  = (cnt_q < CNT_W'(8));
    assign out_valid = flush ? (cnt_q != '0) : (cnt_q >= CNT_W'(8));
    // Bits above the fill count are always zero, so a padded final byte needs no masking.
    assign out_data  = acc_q[7:0];
    assign out_fire  = out_valid && out_ready;

    // Drop the emitted byte first, then append the new word above what remains.
    always_comb begin
        acc_s = acc_q;
        cnt_s = cnt_q;
        if (out_fire) begin
            acc_s = acc_q >> 8;
            cnt_s = (cnt_q > CNT_W'(8)) ? cnt_q - CNT_W'(8) : '0;
        end
        acc_d = acc_s;
        cnt_d = cnt_s;
        if (in_valid) begin
            acc_d = acc_s | ({{(ACC_W-IN_W){1'b0}}, in_data} << cnt_s);
            cnt_d = cnt_s + CNT_W'(IN_W);
        end
    end

    assign drained = (cnt_d == '0);

    // Accumulator and fill-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/poly_ct_pack.sv
// NTRU ciphertext packer: c_j = rh_j + m0_j mod 2^13, first NTRU_N-1
// coefficients packed LSB-first into a byte stream.
// Optional feature macro: PACK_SUMCHK_EN (coefficient sum check on sum_err).
module poly_ct_pack #(
    parameter int NTRU_N     = ntru_pkg::NTRU_N,
    parameter int Q_BITS     = ntru_pkg::Q_BITS,
    parameter int RQ_BITS    = ntru_pkg::RQ_BITS,
    parameter int PACK_BYTES = ntru_pkg::PACK_BYTES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [RQ_BITS-1:0] m0,
    input  logic               rh_valid,
    input  logic [Q_BITS-1:0]  rh_in,
    output logic               rh_ready,
    output logic               byte_valid,
    output logic [7:0]         byte_out,
    input  logic               byte_ready,
    output logic               busy,
    output logic               done,
    output logic               sum_err
);

    import ntru_pkg::*;

    localparam int IDX_W = $clog2(NTRU_N);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RQ_BITS-1:0] m0_sr_q, m0_sr_d;
    logic [Q_BITS-1:0]  coef;
    logic               rh_fire, pack_en, pk_in_ready, pk_drained, is_last;

    assign rh_ready = (state_q == PACK) && pk_in_ready;
    assign rh_fire  = rh_valid && rh_ready;
    assign coef     = rh_in + m0_sr_q[Q_BITS-1:0];
    assign is_last  = (idx_q == IDX_W'(NTRU_N - 1));
    assign pack_en  = rh_fire && !is_last;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    // Next state, coefficient index and message shift register.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        m0_sr_d = m0_sr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PACK;
                    idx_d   = '0;
                    m0_sr_d = m0;
                end
            end
            PACK: begin
                if (rh_fire) begin
                    idx_d   = idx_q + IDX_W'(1);
                    m0_sr_d = m0_sr_q >> Q_BITS;
                    if (is_last) state_d = FLUSH;
                end
            end
            FLUSH:   if (pk_drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and message registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            // NOTE: the message copy is a plain register bank, so it is cleared on reset like any other flop.
            m0_sr_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            m0_sr_q <= m0_sr_d;
        end
    end

    bit_packer #(
        .IN_W (Q_BITS)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pack_en),
        .in_data   (coef),
        .in_ready  (pk_in_ready),
        .flush     (state_q == FLUSH),
        .out_valid (byte_valid),
        .out_data  (byte_out),
        .out_ready (byte_ready),
        .drained   (pk_drained)
    );

`ifdef PACK_SUMCHK_EN
    logic [Q_BITS-1:0] sum_q, sum_d;

    // Running mod-2^13 sum of every coefficient, including the unpacked last one.
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) sum_d = '0;
        else if (rh_fire)             sum_d = sum_q + coef;
    end

    // Sum register.
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign sum_err = (state_q == DONE) && (sum_q != '0);
`else
    assign sum_err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_ct_pack.sv
// Directed self-checking bench for poly_ct_pack.
module tb_poly_ct_pack;

    localparam int N  = 701;
    localparam int QB = 13;
    localparam int RQ = 9113;
    localparam int PB = 1138;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RQ-1:0] m0 = '0;
    logic          rh_valid = 1'b0;
    logic [QB-1:0] rh_in = '0;
    logic          rh_ready;
    logic          byte_valid;
    logic [7:0]    byte_out;
    logic          byte_ready = 1'b0;
    logic          busy, done, sum_err;

    int checks = 0;
    int failures = 0;

    logic [QB-1:0] rh_mem [0:N-1];
    logic [RQ-1:0] m0_vec;
    logic [7:0]    exp_b  [0:PB-1];
    logic [7:0]    got    [0:PB-1];
    logic [7:0]    ref_b  [0:PB-1];
    logic [QB-1:0] exp_sum;
    int            got_n;

    always #5 clk = ~clk;

    poly_ct_pack dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m0         (m0),
        .rh_valid   (rh_valid),
        .rh_in      (rh_in),
        .rh_ready   (rh_ready),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .sum_err    (sum_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_vectors();
        for (int j = 0; j < N; j++) rh_mem[j] = '0;
        m0_vec = '0;
    endtask

    // Bit-position model: stream bit 13j+b is bit b of c_j.
    task automatic build_exp();
        logic [QB-1:0] c;
        int pos;
        for (int i = 0; i < PB; i++) exp_b[i] = 8'h00;
        exp_sum = '0;
        for (int j = 0; j < N; j++) begin
            c = rh_mem[j] + m0_vec[QB*j +: QB];
            exp_sum = exp_sum + c;
            if (j < N - 1) begin
                for (int b = 0; b < QB; b++) begin
                    pos = QB * j + b;
                    exp_b[pos / 8][pos % 8] = c[b];
                end
            end
        end
    endtask

    task automatic run_packet(input string tag, input int stall_at, input int abort_at);
        int rh_idx = 0, stall_cnt = 0, stall_valid = 0;
        int last_at = -1, done_at = -1, hold_err = 0, drop_err = 0, bad = 0;
        logic prev_stall = 1'b0;
        logic [7:0] held = '0;
        logic se_at_done = 1'b0;
        logic exp_se;
        build_exp();
        got_n = 0;
        for (int i = 0; i < PB; i++) got[i] = 8'hxx;
        @(negedge clk);
        m0 = m0_vec;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (prev_stall && !(byte_valid === 1'b1 && byte_out === held)) hold_err++;
            if (done === 1'b1) begin
                done_at = cyc;
                se_at_done = sum_err;
                break;
            end
            if (abort_at >= 0 && got_n == abort_at) break;
            rh_valid = (rh_idx < N);
            rh_in = rh_valid ? rh_mem[rh_idx] : '0;
            byte_ready = 1'b1;
            if (got_n == stall_at && stall_cnt < 10) begin
                byte_ready = 1'b0;
                stall_cnt++;
                if (byte_valid) begin
                    stall_valid++;
                    if (rh_ready !== 1'b0) drop_err++;
                end
            end
            prev_stall = byte_valid && !byte_ready;
            held = byte_out;
            if (rh_valid && rh_ready) rh_idx++;
            if (byte_valid && byte_ready) begin
                if (got_n < PB) got[got_n] = byte_out;
                got_n++;
                last_at = cyc;
            end
            @(negedge clk);
        end
        rh_valid = 1'b0;
        byte_ready = 1'b0;
        if (abort_at >= 0) begin
            check({tag, "_abort_point"}, got_n, abort_at);
            return;
        end
        for (int i = 0; i < PB; i++) if (got[i] !== exp_b[i]) bad++;
        check({tag, "_byte_count"}, got_n, PB);
        check({tag, "_byte_mismatches"}, bad, 0);
        check({tag, "_rh_accepted"}, rh_idx, N);
        check({tag, "_done_latency"}, done_at, last_at + 1);
`ifdef PACK_SUMCHK_EN
        exp_se = (exp_sum != '0);
`else
        exp_se = 1'b0;
`endif
        check({tag, "_sum_err"}, se_at_done, exp_se);
        if (stall_at >= 0) begin
            check({tag, "_stall_seen"}, stall_valid >= 5, 1);
            check({tag, "_hold_errors"}, hold_err, 0);
            check({tag, "_rh_ready_drop_errors"}, drop_err, 0);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_byte_valid", byte_valid, 0);
        check("reset_rh_ready", rh_ready, 0);
        check("reset_sum_err", sum_err, 0);
        rst = 1'b0;

        // All-zero message and product.
        clear_vectors();
        run_packet("zeros", -1, -1);
        check("zeros_b0", got[0], 8'h00);
        check("zeros_blast", got[PB-1], 8'h00);

        // Single full-scale first coefficient.
        clear_vectors();
        rh_mem[0] = 13'h1FFF;
        run_packet("single", -1, -1);
        check("single_b0", got[0], 8'hFF);
        check("single_b1", got[1], 8'h1F);
        check("single_b2", got[2], 8'h00);

        // Carry wraps away: 0x1FFF + 1 = 0 mod 2^13 everywhere.
        clear_vectors();
        for (int j = 0; j < N; j++) begin
            rh_mem[j] = 13'h1FFF;
            m0_vec[QB*j] = 1'b1;
        end
        run_packet("wrap", -1, -1);
        check("wrap_b0", got[0], 8'h00);
        check("wrap_b700", got[700], 8'h00);

        // Ramp rh_j = j, unstalled reference.
        clear_vectors();
        for (int j = 0; j < N; j++) rh_mem[j] = QB'(j);
        run_packet("ramp", -1, -1);
        check("ramp_b1", got[1], 8'h20);
        for (int i = 0; i < PB; i++) ref_b[i] = got[i];

        // Same ramp with 10 cycles of byte backpressure mid-stream.
        run_packet("stall", 300, -1);
        begin
            int diff = 0;
            for (int i = 0; i < PB; i++) if (got[i] !== ref_b[i]) diff++;
            check("stall_vs_unstalled", diff, 0);
        end

        // Reset in the middle of a packet, then a clean rerun.
        run_packet("abort", -1, 500);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_byte_valid", byte_valid, 0);
        check("midrst_rh_ready", rh_ready, 0);
        check("midrst_done", done, 0);
        check("midrst_sum_err", sum_err, 0);
        rst = 1'b0;
        run_packet("after_rst", -1, -1);

        // Sum-check vectors: nonzero sum, then a sum that wraps to zero.
        clear_vectors();
        rh_mem[0] = 13'h0001;
        run_packet("sum_one", -1, -1);
        check("sum_one_b0", got[0], 8'h01);
        rh_mem[N-1] = 13'h1FFF;
        run_packet("sum_zero", -1, -1);
        check("sum_zero_b0", got[0], 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
